// File: rtl/data_memory_subword.sv
// ============================================================================
// Module   : data_memory_subword
// Purpose  : Byte-addressed, little-endian 32-bit data memory with byte/half/
//            word loads and stores, registered load path and sticky
//            misalignment log. Define DATA_MEMORY_FORWARD_EN to forward a
//            same-cycle store into a load of the same word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_subword #(
    parameter int NB_ADDR   = 10,
    parameter int NB_DATA   = 32,
    parameter int RAM_DEPTH = 2 ** (NB_ADDR - 2)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_write_enable,
    input  logic [NB_ADDR-1:0] i_write_address,
    input  logic [1:0]         i_write_size,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_read_enable,
    input  logic [NB_ADDR-1:0] i_read_address,
    input  logic [1:0]         i_read_size,
    input  logic               i_read_unsigned,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_misaligned,
    output logic [NB_ADDR-1:0] o_error_address
);

    localparam logic [1:0] C_SIZE_BYTE = 2'b00;
    localparam logic [1:0] C_SIZE_HALF = 2'b01;
    localparam logic [1:0] C_SIZE_WORD = 2'b10;
    localparam int         C_NB_IDX    = NB_ADDR - 2;

    logic [NB_DATA-1:0] r_mem [RAM_DEPTH];

    logic                w_wr_legal;
    logic                w_rd_legal;
    logic [3:0]          w_wr_strb;
    logic [NB_DATA-1:0]  w_wr_lanes;
    logic [C_NB_IDX-1:0] w_wr_idx;
    logic [C_NB_IDX-1:0] w_rd_idx;
    logic [NB_DATA-1:0]  w_rd_word;
    logic [NB_DATA-1:0]  w_rd_shift;
    logic [NB_DATA-1:0]  w_rd_result;
    logic                w_wr_do;
    logic                w_wr_bad;
    logic                w_rd_bad;

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            C_SIZE_BYTE: is_legal = 1'b1;
            C_SIZE_HALF: is_legal = ~lo[0];
            C_SIZE_WORD: is_legal = (lo == 2'b00);
            default:     is_legal = 1'b0;
        endcase
    endfunction

    assign w_wr_idx   = i_write_address[NB_ADDR-1:2];
    assign w_rd_idx   = i_read_address[NB_ADDR-1:2];
    assign w_wr_legal = is_legal(i_write_size, i_write_address[1:0]);
    assign w_rd_legal = is_legal(i_read_size, i_read_address[1:0]);
    assign w_wr_do    = i_write_enable & w_wr_legal;
    assign w_wr_bad   = i_write_enable & ~w_wr_legal;
    assign w_rd_bad   = i_read_enable & ~w_rd_legal;

    // Replicating the right-justified data across lanes lets the strobe alone pick the target bytes.
    always_comb begin
        w_wr_strb  = 4'b0000;
        w_wr_lanes = i_data;
        case (i_write_size)
            C_SIZE_BYTE: begin
                w_wr_strb  = 4'b0001 << i_write_address[1:0];
                w_wr_lanes = {4{i_data[7:0]}};
            end
            C_SIZE_HALF: begin
                w_wr_strb  = i_write_address[1] ? 4'b1100 : 4'b0011;
                w_wr_lanes = {2{i_data[15:0]}};
            end
            C_SIZE_WORD: w_wr_strb = 4'b1111;
            default:     w_wr_strb = 4'b0000;
        endcase
        if (!w_wr_do) begin
            w_wr_strb = 4'b0000;
        end
    end

`ifdef DATA_MEMORY_FORWARD_EN
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_idx == w_rd_idx) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_strb[k]) begin
                    w_rd_word[8*k +: 8] = w_wr_lanes[8*k +: 8];
                end
            end
        end
    end
`else
    // Read-before-write: a colliding load sees the word as it was before the store.
    assign w_rd_word = r_mem[w_rd_idx];
`endif

    assign w_rd_shift = w_rd_word >> {i_read_address[1:0], 3'b000};

    always_comb begin
        w_rd_result = '0;
        if (w_rd_legal) begin
            case (i_read_size)
                C_SIZE_BYTE: w_rd_result = i_read_unsigned ?
                                 {24'd0, w_rd_shift[7:0]} :
                                 {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
                C_SIZE_HALF: w_rd_result = i_read_unsigned ?
                                 {16'd0, w_rd_shift[15:0]} :
                                 {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
                default:     w_rd_result = w_rd_word;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_strb[k]) begin
                    r_mem[w_wr_idx][8*k +: 8] <= w_wr_lanes[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_read_enable;
            if (i_read_enable) begin
                o_data <= w_rd_result;
            end
        end
    end

    // Only the first offence is recorded; a bad store outranks a bad load in the same cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_misaligned    <= 1'b0;
            o_error_address <= '0;
        end else if (!o_misaligned && (w_wr_bad || w_rd_bad)) begin
            o_misaligned    <= 1'b1;
            o_error_address <= w_wr_bad ? i_write_address : i_read_address;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_subword.sv
// ============================================================================
// Module   : tb_data_memory_subword
// Purpose  : Directed self-checking bench for data_memory_subword.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_subword;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [9:0]  waddr;
    logic [1:0]  wsize;
    logic [31:0] wdata;
    logic        re;
    logic [9:0]  raddr;
    logic [1:0]  rsize;
    logic        runs;
    logic [31:0] rdata;
    logic        rvalid;
    logic        mis;
    logic [9:0]  eaddr;

    int compared   = 0;
    int mismatched = 0;

    data_memory_subword dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_write_enable  (we),
        .i_write_address (waddr),
        .i_write_size    (wsize),
        .i_data          (wdata),
        .i_read_enable   (re),
        .i_read_address  (raddr),
        .i_read_size     (rsize),
        .i_read_unsigned (runs),
        .o_data          (rdata),
        .o_valid         (rvalid),
        .o_misaligned    (mis),
        .o_error_address (eaddr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wsize = 2'b00; wdata = '0;
        re = 1'b0; raddr = '0; rsize = 2'b00; runs = 1'b0;
    endtask

    task automatic st(input logic [9:0] a, input logic [1:0] s, input logic [31:0] d);
        we = 1'b1; waddr = a; wsize = s; wdata = d;
    endtask

    task automatic ld(input logic [9:0] a, input logic [1:0] s, input logic u);
        re = 1'b1; raddr = a; rsize = s; runs = u;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_load(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, {31'd0, rvalid}, 32'd1);
        check({tag, "_data"}, rdata, exp);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        check("rst_data", rdata, 32'h0);
        check("rst_valid", {31'd0, rvalid}, 32'h0);
        check("rst_mis", {31'd0, mis}, 32'h0);
        check("rst_eaddr", {22'd0, eaddr}, 32'h0);
        rst = 1'b0;

        // Word store, then word and sub-word loads
        st(10'h010, 2'b10, 32'h8765_4321); step(); idle();
        ld(10'h010, 2'b10, 1'b0); step(); idle();
        check_load("word_010", 32'h8765_4321);
        ld(10'h013, 2'b00, 1'b0); step();
        check_load("byte_013_s", 32'hFFFF_FF87);
        ld(10'h013, 2'b00, 1'b1); step();
        check_load("byte_013_u", 32'h0000_0087);
        ld(10'h012, 2'b01, 1'b0); step();
        check_load("half_012_s", 32'hFFFF_8765);
        ld(10'h010, 2'b00, 1'b0); step();
        check_load("byte_010_s", 32'h0000_0021);
        ld(10'h010, 2'b01, 1'b1); step();
        check_load("half_010_u", 32'h0000_4321);
        idle();

        // Byte store merge; upper data bits must be ignored
        st(10'h011, 2'b00, 32'hFFFF_FFAB); step(); idle();
        ld(10'h010, 2'b10, 1'b0); step(); idle();
        check_load("merge_010", 32'h8765_AB21);
        step();
        check("idle_valid", {31'd0, rvalid}, 32'h0);
        check("idle_hold", rdata, 32'h8765_AB21);

        // Misaligned word store leaves RAM untouched and logs address
        st(10'h020, 2'b10, 32'hCAFE_F00D); step(); idle();
        check("pre_mis", {31'd0, mis}, 32'h0);
        st(10'h022, 2'b10, 32'hDEAD_BEEF); step(); idle();
        check("mis_set", {31'd0, mis}, 32'h1);
        check("mis_eaddr", {22'd0, eaddr}, 32'h022);
        ld(10'h020, 2'b10, 1'b0); step(); idle();
        check_load("unchanged_020", 32'hCAFE_F00D);
        ld(10'h031, 2'b01, 1'b0); step(); idle();
        check_load("bad_half_031", 32'h0);
        check("eaddr_sticky", {22'd0, eaddr}, 32'h022);
        check("mis_sticky", {31'd0, mis}, 32'h1);

        rst = 1'b1; step(); rst = 1'b0;
        check("rst2_data", rdata, 32'h0);
        check("rst2_valid", {31'd0, rvalid}, 32'h0);
        check("rst2_mis", {31'd0, mis}, 32'h0);
        check("rst2_eaddr", {22'd0, eaddr}, 32'h0);

        // Illegal store and load together: store address wins
        st(10'h051, 2'b10, 32'h1234_5678); ld(10'h033, 2'b01, 1'b0); step(); idle();
        check("both_bad_eaddr", {22'd0, eaddr}, 32'h051);
        check("both_bad_data", rdata, 32'h0);
        rst = 1'b1; step(); rst = 1'b0;
        // Size 11 is illegal even when aligned
        ld(10'h010, 2'b11, 1'b0); step(); idle();
        check_load("size11_load", 32'h0);
        check("size11_eaddr", {22'd0, eaddr}, 32'h010);

        // Same-cycle collision
        st(10'h040, 2'b10, 32'h1111_1111); step(); idle();
        st(10'h040, 2'b00, 32'h0000_00EE); ld(10'h040, 2'b10, 1'b0); step(); idle();
`ifdef DATA_MEMORY_FORWARD_EN
        check_load("collide", 32'h1111_11EE);
`else
        check_load("collide", 32'h1111_1111);
`endif
        ld(10'h040, 2'b10, 1'b0); step(); idle();
        check_load("after_collide", 32'h1111_11EE);
        st(10'h042, 2'b01, 32'h0000_7A5B); step(); idle();
        ld(10'h040, 2'b10, 1'b0); step(); idle();
        check_load("half_store_042", 32'h7A5B_11EE);

        // Reset mid-operation drops the load and the store
        ld(10'h040, 2'b10, 1'b0); step();
        check_load("pre_rst_load", 32'h7A5B_11EE);
        rst = 1'b1; st(10'h040, 2'b10, 32'h5555_5555); step(); idle(); rst = 1'b0;
        check("midrst_valid", {31'd0, rvalid}, 32'h0);
        check("midrst_data", rdata, 32'h0);
        ld(10'h040, 2'b10, 1'b0); step(); idle();
        check_load("store_in_rst_dropped", 32'h7A5B_11EE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_memory_subword.md
Name: data_memory_subword

Overview:
- Next-generation data memory for the pipeline MEM stage.
- Byte-addressed and word-organised, little-endian.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Read is registered (1-cycle latency, valid strobe); misaligned or illegal accesses are detected and logged in a sticky error register.

Parameters:
- NB_ADDR, 10, byte-address width; word index = address[NB_ADDR-1:2].
- NB_DATA, 32, data width; fixed at 32 (4 byte lanes); other values unsupported.
- RAM_DEPTH, 2**(NB_ADDR-2), number of 32-bit words stored.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_write_enable  input  1  store request this cycle.
- i_write_address  input  NB_ADDR  store byte address.
- i_write_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- i_data  input  NB_DATA  store data, right-justified (byte in [7:0], half in [15:0]).
- i_read_enable  input  1  load request this cycle.
- i_read_address  input  NB_ADDR  load byte address.
- i_read_size  input  2  same encoding as i_write_size.
- i_read_unsigned  input  1  1 = zero-extend, 0 = sign-extend (byte/half only).
- o_data  output  NB_DATA  load result, registered.
- o_valid  output  1  o_data holds the result of the previous cycle's load.
- o_misaligned  output  1  sticky error flag.
- o_error_address  output  NB_ADDR  address of the first offending access.

Behaviour:
- Reset (i_reset=1 at a rising edge):
  - o_data=0, o_valid=0, o_misaligned=0, o_error_address=0.
  - Any store presented in the reset cycle is discarded.
  - RAM contents are not cleared.
  - Reset dominates every other input.
- Byte lanes: byte k = address[1:0] occupies bits [8k+7:8k]; a halfword at k∈{0,2} occupies [8k+15:8k].
- Alignment:
  - Byte: always legal.
  - Half: address[0] must be 0.
  - Word: address[1:0] must be 00.
  - Size 11: always illegal.
- Store:
  - Legal store writes only the selected lanes at the rising edge; other lanes are unchanged.
  - Illegal store writes nothing.
- Load (latency 1):
  - A load request in cycle N gives o_valid=1 and o_data=result in cycle N+1.
  - Byte/half result is extracted from its lane, then sign-extended from bit 7/15 or zero-extended per i_read_unsigned. Word result is returned unmodified.
  - Illegal load returns o_data=0 with o_valid=1.
  - With i_read_enable=0: o_valid=0 next cycle and o_data holds its last value.
- Error log:
  - On any illegal load or store, o_misaligned is set next cycle.
  - o_error_address captures the offending address only if o_misaligned was 0.
  - If a load and a store are both illegal in the same cycle, the store address is logged.
  - Cleared only by reset.
- Simultaneous load and store to the same word: behaviour set by the optional feature below. A store and load to different words are independent.
- Addresses beyond RAM_DEPTH cannot occur, since the word index spans the full depth.

Optional Feature:
- Macro: DATA_MEMORY_FORWARD_EN.
- Defined: a load and a legal store to the same word in the same cycle return the merged new word. Stored lanes come from i_data; other lanes come from the RAM. Extraction and extension are then applied.
- Not defined: read-before-write; the load returns the old word contents.
- All other behaviour is identical in both builds.

Test Plan:
- Word store then load:
  - Store 0x8765_4321 word at 0x010; load word at 0x010 next cycle.
  - Following cycle: o_valid=1, o_data=0x8765_4321.
- Sub-word loads from the same word:
  - Byte at 0x013 signed -> 0xFFFF_FF87; unsigned -> 0x0000_0087.
  - Half at 0x012 signed -> 0xFFFF_8765; byte at 0x010 signed -> 0x0000_0021.
- Byte store merge:
  - Store byte 0xAB at 0x011 over 0x8765_4321; word load at 0x010 -> 0x8765_AB21.
- Misalignment:
  - Word store at 0x022 -> RAM unchanged, o_misaligned=1, o_error_address=0x022.
  - Later half load at 0x031 -> o_data=0, o_valid=1, o_error_address stays 0x022.
  - Reset -> all outputs 0.
- Same-cycle collision:
  - Word at 0x040 = 0x1111_1111; same cycle: byte store 0xEE at 0x040 and word load at 0x040.
  - With DATA_MEMORY_FORWARD_EN: 0x1111_11EE. Without: 0x1111_1111. Either build: subsequent load -> 0x1111_11EE.
- Reset mid-operation:
  - Load issued, then reset asserted next cycle -> o_valid=0, o_data=0.
  - Store issued during the reset cycle is discarded; RAM word unchanged.
